// File: rtl/core_pkg.sv
// Shared core types: branch history state and the fetch-time
// prediction tag carried down the pipeline next to each instruction.
package core_pkg;

    localparam int CORE_XLEN   = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BHT_SNT,
        BHT_WNT,
        BHT_WT,
        BHT_ST
    } bht_state;

    typedef struct packed {
        logic                 valid;
        logic [CORE_XLEN-1:0] pc;
        logic                 pred_taken;
        logic [CORE_XLEN-1:0] pred_target;
        logic                 is_branch;
    } pred_tag_t;

endpackage

// File: rtl/pred_tag_stage.sv
// One pipeline register of pred_tag_t.
// Ports: clk, rst (sync, high), hold (stall), clear (flush), d, q.
module pred_tag_stage
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      clear,
    input  pred_tag_t d,
    output pred_tag_t q
);

    // clear has priority over hold so a flush empties a stalled stage
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Carries fetch predictions through D and E, checks them against the
// execute outcome, updates the predictor, flushes/redirects on a
// mispredict and counts branches and mispredicts.
// Ports: IF prediction in, stall_i, id_is_branch_i, ex_* outcome in;
// upd_* predictor write, flush_o/redirect_pc_o, stat_* counters out.
// XLEN must equal core_pkg::CORE_XLEN (tag struct width).
module branch_resolve_unit
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid_i,
    input  logic [XLEN-1:0]  if_pc_i,
    input  logic             if_pred_taken_i,
    input  logic [XLEN-1:0]  if_pred_target_i,
    input  logic             stall_i,
    input  logic             id_is_branch_i,
    input  logic             ex_taken_i,
    input  logic [XLEN-1:0]  ex_target_i,
    output logic             upd_valid_o,
    output logic [XLEN-1:0]  upd_pc_o,
    output logic             upd_taken_o,
    output logic             flush_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] stat_branches_o,
    output logic [CNT_W-1:0] stat_mispred_o
);

    pred_tag_t d_in;
    pred_tag_t d_q;
    pred_tag_t e_in;
    pred_tag_t e_q;
    logic      e_resolved;
    logic      resolve;
    logic      tgt_miss;
    logic      mispred;
    logic [XLEN-1:0] fall_thru;

    assign d_in = '{
        valid:       if_valid_i,
        pc:          if_pc_i,
        pred_taken:  if_pred_taken_i,
        pred_target: if_pred_target_i,
        is_branch:   1'b0
    };

    // decode classifies the D entry as it moves into E
    always_comb begin
        e_in           = d_q;
        e_in.is_branch = id_is_branch_i;
    end

    pred_tag_stage u_d_stage (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall_i),
        .clear (flush_o),
        .d     (d_in),
        .q     (d_q)
    );

    pred_tag_stage u_e_stage (
        .clk   (clk),
        .rst   (rst),
        .hold  (stall_i),
        .clear (flush_o),
        .d     (e_in),
        .q     (e_q)
    );

    // rst gating kills a pending mispredict in the reset cycle itself
    assign resolve = !rst && e_q.valid && e_q.is_branch && !e_resolved;

    assign tgt_miss = e_q.pred_taken && ex_taken_i &&
                      (e_q.pred_target != ex_target_i);

    assign mispred = resolve &&
                     ((e_q.pred_taken != ex_taken_i) || tgt_miss);

    assign fall_thru = e_q.pc + XLEN'(INSTR_BYTES);

    assign upd_valid_o   = resolve;
    assign upd_pc_o      = resolve ? e_q.pc : '0;
    assign upd_taken_o   = resolve && ex_taken_i;
    assign flush_o       = mispred;
    assign redirect_pc_o = !mispred  ? '0 :
                           ex_taken_i ? ex_target_i : fall_thru;

    // a stalled branch resolves once; a newly loaded E entry is fresh
    always_ff @(posedge clk) begin
        if (rst || flush_o || !stall_i) begin
            e_resolved <= 1'b0;
        end else if (resolve) begin
            e_resolved <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            if (resolve) begin
                stat_branches_o <= stat_branches_o + CNT_W'(1);
            end
            if (mispred) begin
                stat_mispred_o <= stat_mispred_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vector table,
// hand sequences for stall/reset, and a random run against a model.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_i;
    logic [31:0] if_pred_target_i;
    logic        stall_i;
    logic        id_is_branch_i;
    logic        ex_taken_i;
    logic [31:0] ex_target_i;
    logic        upd_valid_o;
    logic [31:0] upd_pc_o;
    logic        upd_taken_o;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispred_o;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid_i       (if_valid_i),
        .if_pc_i          (if_pc_i),
        .if_pred_taken_i  (if_pred_taken_i),
        .if_pred_target_i (if_pred_target_i),
        .stall_i          (stall_i),
        .id_is_branch_i   (id_is_branch_i),
        .ex_taken_i       (ex_taken_i),
        .ex_target_i      (ex_target_i),
        .upd_valid_o      (upd_valid_o),
        .upd_pc_o         (upd_pc_o),
        .upd_taken_o      (upd_taken_o),
        .flush_o          (flush_o),
        .redirect_pc_o    (redirect_pc_o),
        .stat_branches_o  (stat_branches_o),
        .stat_mispred_o   (stat_mispred_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model: which instruction sits in D and in E
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] tgt;
        bit          br;
        bit          res;
    } slot_t;

    slot_t md = '{0, 32'h0, 0, 32'h0, 0, 0};
    slot_t me = '{0, 32'h0, 0, 32'h0, 0, 0};
    logic [31:0] mb = 32'h0;
    logic [31:0] mm = 32'h0;

    typedef struct {
        logic [31:0] pc;
        bit          pt;
        logic [31:0] ptgt;
        bit          xt;
        logic [31:0] xtgt;
        bit          fl;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [5];
    int   eb;
    int   em;
    int   nf;
    int   nu;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endfunction

    // a branch in E resolves once; it is wrong if direction differs,
    // or both say taken but to different places
    function automatic void calc(output bit r, output bit m);
        r = !rst && me.v && me.br && !me.res;
        m = r && ((me.pt != ex_taken_i) ||
                  (me.pt && ex_taken_i && me.tgt != ex_target_i));
    endfunction

    task automatic model_check();
        bit r;
        bit m;
        logic [31:0] rd;
        if (!chk_en) return;
        calc(r, m);
        rd = 32'h0;
        if (m) rd = ex_taken_i ? ex_target_i : me.pc + 32'd4;
        chk("m_upd_valid", {31'h0, upd_valid_o}, {31'h0, r});
        chk("m_upd_pc", upd_pc_o, r ? me.pc : 32'h0);
        chk("m_upd_taken", {31'h0, upd_taken_o},
            {31'h0, r & ex_taken_i});
        chk("m_flush", {31'h0, flush_o}, {31'h0, m});
        chk("m_redirect", redirect_pc_o, rd);
        chk("m_branches", stat_branches_o, mb);
        chk("m_mispred", stat_mispred_o, mm);
    endtask

    task automatic model_update();
        bit r;
        bit m;
        calc(r, m);
        if (rst) begin
            md.v = 0; me.v = 0; me.res = 0;
            mb = 0; mm = 0;
        end else begin
            mb = mb + 32'(r);
            mm = mm + 32'(m);
            if (m) begin
                md.v = 0; me.v = 0; me.res = 0;
            end else if (stall_i) begin
                if (r) me.res = 1;
            end else begin
                me = '{md.v, md.pc, md.pt, md.tgt, id_is_branch_i, 0};
                md = '{if_valid_i, if_pc_i, if_pred_taken_i,
                       if_pred_target_i, 0, 0};
            end
        end
    endtask

    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; if_valid_i = 0; if_pc_i = 0;
        if_pred_taken_i = 0; if_pred_target_i = 0;
        stall_i = 0; id_is_branch_i = 0;
        ex_taken_i = 0; ex_target_i = 0;
    endtask

    task automatic fetch(logic [31:0] pc, bit pt, logic [31:0] tg);
        if_valid_i = 1; if_pc_i = pc;
        if_pred_taken_i = pt; if_pred_target_i = tg;
    endtask

    initial begin
        tbl[0] = '{32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h0};
        tbl[1] = '{32'h200, 0, 32'h0,   1, 32'h240, 1, 32'h240};
        tbl[2] = '{32'h300, 1, 32'h380, 1, 32'h3C0, 1, 32'h3C0};
        tbl[3] = '{32'hFFFFFFFC, 1, 32'h10, 0, 32'h0, 1, 32'h0};
        tbl[4] = '{32'h400, 1, 32'h480, 1, 32'h480, 0, 32'h0};

        idle();
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        #1;
        chk("rst_upd_valid", {31'h0, upd_valid_o}, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_redirect", redirect_pc_o, 32'h0);
        chk("rst_branches", stat_branches_o, 32'h0);
        chk("rst_mispred", stat_mispred_o, 32'h0);
        tick();

        eb = 0;
        em = 0;
        foreach (tbl[i]) begin
            idle();
            fetch(tbl[i].pc, tbl[i].pt, tbl[i].ptgt);
            tick();
            fetch(tbl[i].pc + 32'd4, 0, 32'h0);
            id_is_branch_i = 1;
            tick();
            fetch(tbl[i].pc + 32'd8, 0, 32'h0);
            ex_taken_i = tbl[i].xt;
            ex_target_i = tbl[i].xtgt;
            #1;
            chk("v_upd_valid", {31'h0, upd_valid_o}, 32'h1);
            chk("v_upd_pc", upd_pc_o, tbl[i].pc);
            chk("v_upd_taken", {31'h0, upd_taken_o},
                {31'h0, tbl[i].xt});
            chk("v_flush", {31'h0, flush_o}, {31'h0, tbl[i].fl});
            chk("v_redirect", redirect_pc_o, tbl[i].rd);
            tick();
            eb++;
            em += int'(tbl[i].fl);
            if_valid_i = 0;
            ex_taken_i = 0;
            ex_target_i = 0;
            #1;
            chk("v_branches", stat_branches_o, 32'(eb));
            chk("v_mispred", stat_mispred_o, 32'(em));
            for (int k = 0; k < 2; k++) begin
                #1;
                chk("v_younger", {31'h0, upd_valid_o},
                    {31'h0, !tbl[i].fl});
                tick();
            end
            if (!tbl[i].fl) eb += 2;
        end

        // mispredict held in E by a stall
        idle();
        fetch(32'h500, 0, 32'h0);
        tick();
        if_valid_i = 0;
        id_is_branch_i = 1;
        tick();
        id_is_branch_i = 0;
        ex_taken_i = 1;
        ex_target_i = 32'h540;
        stall_i = 1;
        nf = 0;
        nu = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nf += int'(flush_o);
            nu += int'(upd_valid_o);
            tick();
        end
        eb++;
        em++;
        chk("stall_flush_cnt", 32'(nf), 32'h1);
        chk("stall_upd_cnt", 32'(nu), 32'h1);
        chk("stall_branches", stat_branches_o, 32'(eb));
        chk("stall_mispred", stat_mispred_o, 32'(em));

        // correct prediction held in E by a stall
        idle();
        fetch(32'h600, 1, 32'h680);
        tick();
        if_valid_i = 0;
        id_is_branch_i = 1;
        tick();
        id_is_branch_i = 0;
        ex_taken_i = 1;
        ex_target_i = 32'h680;
        stall_i = 1;
        nf = 0;
        nu = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            nf += int'(flush_o);
            nu += int'(upd_valid_o);
            tick();
        end
        eb++;
        chk("hold_flush_cnt", 32'(nf), 32'h0);
        chk("hold_upd_cnt", 32'(nu), 32'h1);
        chk("hold_branches", stat_branches_o, 32'(eb));
        chk("hold_mispred", stat_mispred_o, 32'(em));
        idle();
        tick();

        // reset while a mispredict is pending
        fetch(32'h700, 0, 32'h0);
        tick();
        if_valid_i = 0;
        id_is_branch_i = 1;
        tick();
        id_is_branch_i = 0;
        ex_taken_i = 1;
        ex_target_i = 32'h740;
        rst = 1;
        #1;
        chk("rstm_flush", {31'h0, flush_o}, 32'h0);
        chk("rstm_upd", {31'h0, upd_valid_o}, 32'h0);
        tick();
        idle();
        #1;
        chk("rsta_flush", {31'h0, flush_o}, 32'h0);
        chk("rsta_upd", {31'h0, upd_valid_o}, 32'h0);
        chk("rsta_upd_pc", upd_pc_o, 32'h0);
        chk("rsta_redirect", redirect_pc_o, 32'h0);
        chk("rsta_branches", stat_branches_o, 32'h0);
        chk("rsta_mispred", stat_mispred_o, 32'h0);
        tick();

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if_valid_i = 1'($urandom_range(0, 1));
            if_pc_i = $urandom() & 32'hFFFF_FFFC;
            if_pred_taken_i = 1'($urandom_range(0, 1));
            if_pred_target_i = $urandom() & 32'hFFFF_FFFC;
            stall_i = ($urandom_range(0, 3) == 0);
            id_is_branch_i = ($urandom_range(0, 2) != 0);
            ex_taken_i = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: ex_target_i = me.tgt;
                1: ex_target_i = me.pc + 32'd4;
                default: ex_target_i = $urandom();
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side partner of the 2-bit branch predictor. Carries each fetch-time prediction (taken bit and predicted target) down the IF/ID and ID/EX stages, compares it against the actual branch outcome from execute, and drives the predictor's history-table update port. On a misprediction it raises a pipeline flush and a fetch redirect PC. It also keeps branch and misprediction statistics counters.

## Interface
Parameters:
- `XLEN`, 32, PC and target width.
- `CNT_W`, 32, statistics counter width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `if_valid_i`  in  1  fetch holds a real instruction this cycle.
- `if_pc_i`  in  XLEN  PC of the fetched instruction.
- `if_pred_taken_i`  in  1  predictor output for `if_pc_i`.
- `if_pred_target_i`  in  XLEN  fetch-computed target (PC+imm); meaningful only when predicted taken.
- `stall_i`  in  1  hold the IF/ID and ID/EX stages.
- `id_is_branch_i`  in  1  decode marks the D-stage entry as a conditional branch.
- `ex_taken_i`  in  1  actual branch outcome of the E-stage entry.
- `ex_target_i`  in  XLEN  actual taken target of the E-stage entry.
- `upd_valid_o`  out  1  write enable for the predictor update.
- `upd_pc_o`  out  XLEN  PC whose history entry is updated.
- `upd_taken_o`  out  1  actual outcome for the update.
- `flush_o`  out  1  kill the IF, ID and EX younger work.
- `redirect_pc_o`  out  XLEN  next fetch PC when `flush_o` is high.
- `stat_branches_o`  out  CNT_W  number of resolved branches.
- `stat_mispred_o`  out  CNT_W  number of mispredicted branches.

## Operation
- Each of the two tag stages, D and E, holds: `valid`, `pc`, `pred_taken`, `pred_target`, `is_branch`. The E stage also holds a `resolved` flag.
- Advance when `stall_i`=0 and no flush:
  - D is loaded from the IF inputs (`valid` = `if_valid_i`).
  - E is loaded from D, with `is_branch` = `id_is_branch_i` and `resolved`=0.
- When `stall_i`=1, both stages hold their contents.
- An E entry is resolvable when `valid` & `is_branch` & !`resolved`. In that cycle:
  - `upd_valid_o`=1, `upd_pc_o`=E.pc, `upd_taken_o`=`ex_taken_i`.
  - `stat_branches_o` increments at the clock edge.
- Mispredict when the entry is resolvable and either:
  - `pred_taken` != `ex_taken_i`, or
  - `pred_taken` & `ex_taken_i` & (`pred_target` != `ex_target_i`).
- On a mispredict:
  - `flush_o`=1.
  - `redirect_pc_o` = `ex_taken_i` ? `ex_target_i` : E.pc+4. The addition is modulo 2^XLEN.
  - `stat_mispred_o` increments.
- `resolved` is set at the edge after resolution. A stalled branch therefore updates, flushes and counts exactly once.
- On flush, at the next edge:
  - D.valid, E.valid = 0, regardless of `stall_i` (flush beats stall).
  - The current IF inputs are dropped.
- Non-branch or invalid E entry: `upd_valid_o`=0 and `flush_o`=0.
- When `flush_o`=0, `redirect_pc_o`=0.
- Counters wrap at 2^CNT_W.
- Reset clears all valid and resolved flags and both counters. All outputs read 0 in the cycle after `rst` is sampled high. Reset during a pending mispredict discards it: no flush and no count.

## Timing
- `upd_*`, `flush_o` and `redirect_pc_o` are combinational from E state and the `ex_*` inputs, valid in the same cycle the branch sits in E (zero latency). The predictor writes on the following rising edge.
- Prediction-to-resolution latency is 2 cycles without stalls: an instruction in IF at cycle n is in E at cycle n+2.
- The first fetched instruction after a flush enters D at the edge after the flush cycle.
- Statistics outputs are registered and reflect a resolution one cycle after the event.
- Stall and flush in the same cycle: flush wins and the stages clear.

## Structure
- Add to `CORE_PKG`:
  - typedef `pred_tag_t` {valid, pc, pred_taken, pred_target, is_branch}.
  - constant `INSTR_BYTES`=4.
- The existing `bht_state` typedef is untouched.
- Sub-module `pred_tag_stage`: one pipeline register of `pred_tag_t` with hold (stall) and clear (flush/reset) inputs. It is instantiated twice; E adds the `resolved` flag locally.
- Compare, redirect and counter logic stay in the top module.

## Test plan
- Branch at PC 0x100, predicted not-taken, actual not-taken -> 2 cycles later `upd_valid_o`=1, `upd_pc_o`=0x100, `upd_taken_o`=0, `flush_o`=0; branches=1, mispred=0.
- Branch at 0x200 predicted not-taken, actual taken to 0x240 -> `flush_o`=1, `redirect_pc_o`=0x240. Next cycle both stages are invalid and mispred=1.
- Branch at 0x300 predicted taken to 0x380, actual taken to 0x3C0 -> `flush_o`=1, `redirect_pc_o`=0x3C0.
- Branch at 0xFFFFFFFC predicted taken, actual not-taken -> `redirect_pc_o`=0x00000000 (wrap).
- Mispredicted branch in E with `stall_i`=1 for 3 cycles -> `flush_o` and `upd_valid_o` high for exactly 1 cycle; counters increment once; the stages clear despite the stall.
- Assert `rst` for one cycle while a mispredicting branch sits in E -> no flush, all outputs 0, counters 0 afterward.
